// File: rtl/prim_rr_onehot_sched.sv
// Round-robin scheduler with onehot + binary grant under valid/ready, and a
// sticky integrity checker over the registered grant vector, index and valid.
// The previous winner gets lowest priority. Pointer wrap uses NumReq, so
// non-power-of-two requester counts never alias onto an unused index.
module prim_rr_onehot_sched #(
    parameter int unsigned NumReq   = 4,
    localparam int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_i,
    output logic [NumReq-1:0]   gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                valid_o,
    input  logic                ready_i,
    input  logic                err_clr_i,
    output logic                err_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic [NumReq-1:0]   gnt_r;
    logic [NumReq-1:0]   gnt_nxt_s;
    logic [IdxWidth-1:0] idx_r;
    logic [IdxWidth-1:0] idx_nxt_s;
    logic                valid_r;
    logic                valid_nxt_s;
    logic [IdxWidth-1:0] ptr_r;
    logic [IdxWidth-1:0] ptr_nxt_s;
    logic [IdxWidth-1:0] win_s;
    logic                err_r;
    logic                err_now_s;

    // Advance an index by one, wrapping at NumReq-1 rather than 2**IdxWidth.
    function automatic logic [IdxWidth-1:0] ptr_inc(input logic [IdxWidth-1:0] p);
        logic [IdxWidth-1:0] r;
        if (p == IdxWidth'(NumReq - 32'd1)) begin
            r = '0;
        end else begin
            r = p + IdxWidth'(1);
        end
        return r;
    endfunction

    // First set request scanning upward from start, wrapping modulo NumReq.
    function automatic logic [IdxWidth-1:0] rr_pick(input logic [NumReq-1:0]   req,
                                                    input logic [IdxWidth-1:0] start);
        logic [IdxWidth-1:0] cand;
        logic [IdxWidth-1:0] res;
        logic                found;
        cand  = start;
        res   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!found && req[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
            cand = ptr_inc(cand);
        end
        return res;
    endfunction

    // Onehot decode of a (known in-range) index.
    function automatic logic [NumReq-1:0] idx_dec(input logic [IdxWidth-1:0] ix);
        logic [NumReq-1:0] d;
        d     = '0;
        d[ix] = 1'b1;
        return d;
    endfunction

    // True when exactly one bit of the vector is set.
    function automatic logic onehot_ok(input logic [NumReq-1:0] v);
        int unsigned cnt;
        cnt = 32'd0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return (cnt == 32'd1);
    endfunction

    // Consistency of grant vector, index and valid bit.
    function automatic logic integrity_err(input logic                v,
                                           input logic [NumReq-1:0]   g,
                                           input logic [IdxWidth-1:0] ix);
        logic idx_oob;
        logic sel;
        logic bad;
        idx_oob = (32'(ix) >= NumReq);
        sel     = idx_oob ? 1'b0 : g[ix];
        if (v) begin
            bad = !onehot_ok(g) || idx_oob || !sel;
        end else begin
            bad = |g;
        end
        return bad;
    endfunction

    // Next-state, arbitration and next-grant computation.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        idx_nxt_s   = idx_r;
        valid_nxt_s = valid_r;
        ptr_nxt_s   = ptr_r;
        win_s       = '0;
        case (state_r)
            ST_IDLE: begin
                if (|req_i) begin
                    win_s       = rr_pick(req_i, ptr_r);
                    gnt_nxt_s   = idx_dec(win_s);
                    idx_nxt_s   = win_s;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_GRANT;
                end else begin
                    gnt_nxt_s   = '0;
                    idx_nxt_s   = '0;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ready_i) begin
                    // Handshake: previous winner drops to lowest priority.
                    ptr_nxt_s = ptr_inc(idx_r);
                    if (|req_i) begin
                        win_s       = rr_pick(req_i, ptr_inc(idx_r));
                        gnt_nxt_s   = idx_dec(win_s);
                        idx_nxt_s   = win_s;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_GRANT;
                    end else begin
                        gnt_nxt_s   = '0;
                        idx_nxt_s   = '0;
                        valid_nxt_s = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    // Grant is held stable until accepted, whatever req_i does.
                    gnt_nxt_s   = gnt_r;
                    idx_nxt_s   = idx_r;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                gnt_nxt_s   = '0;
                idx_nxt_s   = '0;
                valid_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant and priority-pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            idx_r   <= idx_nxt_s;
            valid_r <= valid_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Integrity check over the registered outputs.
    always_comb begin
        err_now_s = integrity_err(valid_r, gnt_r, idx_r);
    end

    // Sticky error: a new error wins over a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (err_now_s) begin
            err_r <= 1'b1;
        end else if (err_clr_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign gnt_o   = gnt_r;
    assign idx_o   = idx_r;
    assign valid_o = valid_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_prim_rr_onehot_sched.sv
// Bench for prim_rr_onehot_sched: directed phases plus random traffic against
// a queue-based round-robin reference, checked by an independent monitor.
// A second instance with three requesters exercises the modulo-3 wrap.
module tb_prim_rr_onehot_sched;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic       ready_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [3:0] gnt_o;
    logic [1:0] idx_o;
    logic       valid_o;
    logic       err_o;

    logic       r3_rst = 1'b1;
    logic [2:0] r3_req = 3'b000;
    logic       r3_ready = 1'b0;
    logic       r3_clr = 1'b0;
    logic [2:0] g3;
    logic [1:0] i3;
    logic       v3;
    logic       e3;

    int errors = 0;
    int checks = 0;

    // Reference model state: queue of expected grant indices in order.
    int q[$];
    int m_ptr = 0;
    int m_cur = 0;
    bit m_busy = 1'b0;
    bit m_err = 1'b0;
    bit m_force = 1'b0;
    bit skip = 1'b0;

    always #5 clk = ~clk;

    prim_rr_onehot_sched #(.NumReq(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .idx_o(idx_o),
        .valid_o(valid_o), .ready_i(ready_i), .err_clr_i(err_clr_i), .err_o(err_o)
    );

    prim_rr_onehot_sched #(.NumReq(3)) dut3 (
        .clk_i(clk), .rst_i(r3_rst), .req_i(r3_req), .gnt_o(g3), .idx_o(i3),
        .valid_o(v3), .ready_i(r3_ready), .err_clr_i(r3_clr), .err_o(e3)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Apply the spec rules for one clock edge using the inputs now applied.
    task automatic model_step();
        if (rst_i) begin
            q.delete();
            m_ptr  = 0;
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (m_force) m_err = 1'b1;
            else if (err_clr_i) m_err = 1'b0;
            if (!m_busy) begin
                if (req_i != 4'b0000) begin
                    m_cur  = pick(req_i, m_ptr);
                    m_busy = 1'b1;
                    q.push_back(m_cur);
                end
            end else if (ready_i) begin
                m_ptr = (m_cur + 1) % N;
                if (req_i != 4'b0000) begin
                    m_cur = pick(req_i, m_ptr);
                    q.push_back(m_cur);
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    // One clock: model the edge, then drive inputs for the next edge.
    task automatic cyc(input bit r, input logic [3:0] rq, input bit rd, input bit cl);
        @(posedge clk);
        model_step();
        #1;
        rst_i     = r;
        req_i     = rq;
        ready_i   = rd;
        err_clr_i = cl;
    endtask

    // Monitor: compare presented grant against the scoreboard head.
    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        bit         exp_valid;
        if (!skip) begin
            exp_valid = (q.size() != 0);
            checks++;
            if (valid_o !== exp_valid) begin
                errors++;
                $display("FAIL valid: got %0b want %0b at %0t", valid_o, exp_valid, $time);
            end
            if (valid_o === 1'b1 && exp_valid) begin
                exp_gnt = 4'b0001 << q[0];
                checks++;
                if (idx_o !== 2'(q[0]) || gnt_o !== exp_gnt) begin
                    errors++;
                    $display("FAIL grant: got idx=%0d gnt=%b want idx=%0d gnt=%b at %0t",
                             idx_o, gnt_o, q[0], exp_gnt, $time);
                end
            end else if (valid_o !== 1'b1) begin
                checks++;
                if (gnt_o !== 4'b0000) begin
                    errors++;
                    $display("FAIL idle_gnt: got %b want 0000 at %0t", gnt_o, $time);
                end
            end
        end
        checks++;
        if (err_o !== m_err) begin
            errors++;
            $display("FAIL err: got %0b want %0b at %0t", err_o, m_err, $time);
        end
        if (valid_o === 1'b1 && ready_i && q.size() != 0) void'(q.pop_front());
    end

    task automatic chk3(input int ei, input string nm);
        logic [2:0] eg;
        eg = 3'b001 << ei;
        checks++;
        if (v3 !== 1'b1 || i3 !== 2'(ei) || g3 !== eg || e3 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%0b idx=%0d gnt=%b err=%0b want valid=1 idx=%0d gnt=%b err=0",
                     nm, v3, i3, g3, e3, ei, eg);
        end
    endtask

    // Three-requester instance: wrap from index 2 goes to 0, never 3.
    initial begin
        @(posedge clk); #1 r3_rst = 1'b1;
        @(posedge clk); #1 r3_rst = 1'b0; r3_req = 3'b100; r3_ready = 1'b0;
        @(posedge clk);
        @(negedge clk); chk3(2, "n3_first");
        r3_req = 3'b101; r3_ready = 1'b1;
        @(negedge clk); chk3(0, "n3_wrap");
        @(negedge clk); chk3(2, "n3_second");
        @(negedge clk); chk3(0, "n3_wrap2");
        r3_req = 3'b000; r3_ready = 1'b0;
    end

    // Main stimulus sequence.
    initial begin
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        // Single request, grant held without ready.
        cyc(0, 4'b0100, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        // All requesting, always ready: back-to-back rotation.
        repeat (10) cyc(0, 4'b1111, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        // Hold grant to 1 while request set changes.
        cyc(1, 4'b0000, 0, 0);
        cyc(0, 4'b0010, 0, 0);
        repeat (5) cyc(0, 4'b1000, 0, 0);
        cyc(0, 4'b1000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        // Reset while a grant is pending, then 1001 must go to index 0.
        cyc(0, 4'b0100, 0, 0);
        cyc(0, 4'b0100, 0, 0);
        cyc(1, 4'b0100, 0, 0);
        cyc(0, 4'b1001, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0);
        // Corrupt a valid grant: not onehot and wrong selected bit.
        cyc(0, 4'b0001, 0, 0);
        cyc(0, 4'b0001, 0, 0);
        force dut.gnt_r = 4'b0110;
        m_force = 1'b1;
        skip    = 1'b1;
        cyc(0, 4'b0000, 0, 0);
        release dut.gnt_r;
        m_force = 1'b0;
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0);
        skip = 1'b0;
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 1);
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        // Clear coincident with a fresh error: error wins.
        force dut.gnt_r = 4'b0001;
        err_clr_i = 1'b1;
        m_force   = 1'b1;
        skip      = 1'b1;
        cyc(0, 4'b0000, 0, 0);
        release dut.gnt_r;
        m_force = 1'b0;
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0);
        skip = 1'b0;
        cyc(0, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 1);
        cyc(0, 4'b0000, 0, 0);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rq;
            rq = 4'($urandom);
            if ($urandom_range(0, 4) == 0) rq = 4'b0000;
            cyc(($urandom_range(0, 199) == 0), rq,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prim_rr_onehot_sched.md
Name: prim_rr_onehot_sched

Overview:
- Round-robin scheduler that shares one downstream resource between NumReq requesters.
- Each grant is issued as both a onehot vector and a binary index, held under a valid/ready handshake until accepted.
- An integrated onehot/address consistency checker raises a sticky error on any mismatch between the grant vector, the index and the valid bit.
- Sits in front of onehot-selected datapaths (muxes, register banks) whose select integrity must be alert-checked.

Parameters:
- NumReq, 4, number of requesters; legal range 2..32.
- IdxWidth, $clog2(NumReq), width of the binary grant index; derived, not overridden.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_i  input  NumReq  per-requester request level.
- gnt_o  output  NumReq  onehot grant; all-zero when valid_o=0.
- idx_o  output  IdxWidth  binary index of the granted requester.
- valid_o  output  1  grant is valid and presented downstream.
- ready_i  input  1  downstream accepts the current grant.
- err_clr_i  input  1  clears the sticky error.
- err_o  output  1  sticky integrity error.

Behaviour:
- Reset (rst_i=1 sampled on an edge) forces the following on the next edge:
  - gnt_o=0, idx_o=0, valid_o=0, err_o=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - FSM=IDLE.
  - Reset overrides every other input in the same cycle. A grant pending mid-operation is dropped without a handshake.
- FSM has two states:
  - IDLE: valid_o=0, gnt_o=0. If |req_i, arbitrate, register gnt_o/idx_o, set valid_o=1 and go to GRANT. Latency is one cycle from request to valid_o.
  - GRANT: valid_o=1. gnt_o and idx_o are held stable regardless of req_i; a dropped req_i does not revoke the grant. On valid_o && ready_i (handshake):
    - ptr <= (idx_o+1) mod NumReq.
    - If req_i has any bit set in that cycle, re-arbitrate the same cycle using the updated priority (ptr = idx_o+1, wrapping) and stay in GRANT with new gnt_o/idx_o. This gives back-to-back grants with no bubble.
    - Otherwise go to IDLE.
- Arbitration:
  - Pick the first set bit of req_i scanning upward from ptr, wrapping from NumReq-1 to 0.
  - The previous winner is considered last, so a single persistent requester is re-granted every handshake.
  - Wrap uses mod NumReq, not 2**IdxWidth, for non-power-of-two NumReq.
- Integrity check, combinational on registered outputs, evaluated every cycle outside reset. err_now is asserted if any of the following hold:
  - valid_o=1 and gnt_o not exactly onehot.
  - valid_o=1 and gnt_o[idx_o]=0.
  - valid_o=1 and idx_o >= NumReq.
  - valid_o=0 and |gnt_o.
- err_o is sticky:
  - Set on the edge after err_now.
  - Cleared on the edge after err_clr_i=1.
  - Set wins if err_now and err_clr_i occur in the same cycle.
  - err_o does not block scheduling.
- Arithmetic: ptr is IdxWidth bits. Increments compare against NumReq-1 explicitly; there is no overflow aliasing.

Test Plan:
- Reset, then req_i=4'b0100 -> valid_o=1 one cycle later, gnt_o=4'b0100, idx_o=2, err_o=0.
- req_i=4'b1111 held, ready_i=1 every cycle -> grants cycle 0,1,2,3,0 on consecutive cycles with no bubble; gnt_o always onehot.
- Grant to req 1 with ready_i=0 for 5 cycles while req_i changes to 4'b1000 -> gnt_o stays 4'b0010, idx_o=1. After ready_i=1, the next grant is 4'b1000.
- NumReq=3, req_i=3'b101 after a grant to idx 2 -> next grant idx 0 (wrap mod 3), never idx 3.
- Force gnt_o to 4'b0110 with valid_o=1 -> err_o=1 next cycle and stays 1. err_clr_i pulse with no further error -> err_o=0. err_clr_i coincident with a forced error -> err_o stays 1.
- rst_i asserted while valid_o=1 and ready_i=0 -> next cycle valid_o=0, gnt_o=0, ptr=0. With req_i=4'b1001, the following grant is idx 0.
